// File: rtl/bus_move_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_move_pkg
// Purpose : Shared state encoding, move record and width helper for the
//           bus move scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package bus_move_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Move fields are stored at a fixed width so the record is configuration independent.
    localparam int c_FieldW = 8;

    typedef struct packed {
        logic [c_FieldW-1:0] src;
        logic [c_FieldW-1:0] dst;
        logic [c_FieldW-1:0] reqId;
    } move_t;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_move_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Round-robin arbiter; combinational one-hot grant, registered
//           priority pointer that moves past the winner on each accept.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import bus_move_pkg::*;
#(
    parameter  int NumReq = 2,
    localparam int IdW    = idxWidth(NumReq)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NumReq-1:0] req,
    input  logic              advance,
    output logic [NumReq-1:0] grant,
    output logic [IdW-1:0]    grantId,
    output logic              anyReq
);

    logic [IdW-1:0] r_ptr;

    function automatic logic [IdW-1:0] wrapIdx(input int v);
        return IdW'(v % NumReq);
    endfunction

    // Scan from lowest to highest priority so the requester at the pointer wins last.
    always_comb begin
        anyReq  = |req;
        grantId = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req[wrapIdx(int'(r_ptr) + k)]) begin
                grantId = wrapIdx(int'(r_ptr) + k);
            end
        end
        grant = anyReq ? (NumReq'(1) << grantId) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= wrapIdx(int'(grantId) + 1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : bus_move_scheduler
// Purpose : Arbitrates register-to-register moves and sequences the bank's
//           one-hot OutEnable/InEnable strobes around the one-cycle latency.
//           Define BUS_MOVE_PIPELINE_EN to overlap issue with the prior latch.
// Revision: 1.0 - initial release
// ============================================================================
module bus_move_scheduler
    import bus_move_pkg::*;
#(
    parameter  int NumRegs = 8,
    parameter  int NumReq  = 2,
    localparam int IdxW    = idxWidth(NumRegs),
    localparam int IdW     = idxWidth(NumReq)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NumReq-1:0]      ReqValid,
    input  logic [NumReq*IdxW-1:0] ReqSrc,
    input  logic [NumReq*IdxW-1:0] ReqDst,
    output logic [NumReq-1:0]      ReqReady,
    output logic [NumRegs-1:0]     OutEnable,
    output logic [NumRegs-1:0]     InEnable,
    output logic                   DoneValid,
    output logic [IdW-1:0]         DoneId,
    output logic                   Busy
);

    state_t            r_state;
    state_t            w_stateNext;
    move_t             r_move;
    move_t             w_issue;
    logic              r_doneValid;
    logic [IdW-1:0]    r_doneId;
    logic [NumReq-1:0] w_grant;
    logic [IdW-1:0]    w_grantId;
    logic              w_anyValid;
    logic              w_issueSlot;
    logic              w_accept;
    logic              w_unusedSrc;
    logic [IdxW-1:0]   w_src [NumReq];
    logic [IdxW-1:0]   w_dst [NumReq];

    for (genvar i = 0; i < NumReq; i++) begin : g_unpack
        assign w_src[i] = ReqSrc[i*IdxW +: IdxW];
        assign w_dst[i] = ReqDst[i*IdxW +: IdxW];
    end

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_arbiter (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (ReqValid),
        .advance (w_accept),
        .grant   (w_grant),
        .grantId (w_grantId),
        .anyReq  (w_anyValid)
    );

    always_comb begin
        w_issue       = '0;
        w_issue.src   = c_FieldW'(w_src[w_grantId]);
        w_issue.dst   = c_FieldW'(w_dst[w_grantId]);
        w_issue.reqId = c_FieldW'(w_grantId);
    end

`ifdef BUS_MOVE_PIPELINE_EN
    // Reading the register being written this cycle would return its stale value.
    logic w_hazard;
    assign w_hazard    = (w_issue.src == r_move.dst);
    assign w_issueSlot = (r_state == DRIVE) || ((r_state == LATCH) && !w_hazard);
`else
    assign w_issueSlot = (r_state == DRIVE);
`endif

    assign w_accept    = w_issueSlot && w_anyValid;
    assign ReqReady    = w_accept ? w_grant : '0;
    assign DoneValid   = r_doneValid;
    assign DoneId      = r_doneId;
    assign Busy        = (r_state != IDLE) || r_doneValid;
    assign w_unusedSrc = ^r_move.src;

    // Out-of-range indices match no register, so the move completes with no strobe.
    for (genvar g = 0; g < NumRegs; g++) begin : g_strobe
        assign OutEnable[g] = w_accept && (w_issue.src == c_FieldW'(g));
        assign InEnable[g]  = (r_state == LATCH) && (r_move.dst == c_FieldW'(g));
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_anyValid) w_stateNext = DRIVE;
            DRIVE:   w_stateNext = w_accept ? LATCH : IDLE;
            LATCH: begin
                if (w_accept)        w_stateNext = LATCH;
                else if (w_anyValid) w_stateNext = DRIVE;
                else                 w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_move      <= '0;
            r_doneValid <= 1'b0;
            r_doneId    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_doneValid <= (r_state == LATCH);
            if (w_accept) begin
                r_move <= w_issue;
            end
            if (r_state == LATCH) begin
                r_doneId <= IdW'(r_move.reqId);
            end
        end
    end

endmodule
`default_nettype wire
